// File: rtl/quiz_pkg.sv
// Shared constants for the quiz round controller: FSM state encodings,
// score width and the answer-choice width helper.
package quiz_pkg;

    localparam int SCORE_W = 4;

    typedef logic [1:0] state_t;
    localparam state_t ST_ASK     = 2'd0;
    localparam state_t ST_RELEASE = 2'd1;
    localparam state_t ST_DONE    = 2'd2;

    // Choices are encoded 1..n with 0 reserved for "no valid question".
    function automatic int choice_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus falling-edge detector for active-low buttons.
// All flops reset to ones (released), so no edge is reported out of reset.
module btn_sync_edge #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] sync,
    output logic [W-1:0] fall
);

    logic [W-1:0] s1, s2, prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= '1;
            s2   <= '1;
            prev <= '1;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign sync = s2;
    assign fall = prev & ~s2;

endmodule

// File: rtl/quiz_round_ctrl.sv
// Quiz round controller: arbitrates first valid answer, scores, locks out
// wrong answerers and declares a winner. Optional answer timer: QUIZ_TIMEOUT_EN.
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int NUM_PLAYERS    = 2,
    parameter int NUM_CHOICES    = 4,
    parameter int NUM_QUESTIONS  = 10,
    parameter int WIN_SCORE      = 5,
    parameter int TIMEOUT_CYCLES = 1000,
    localparam int CW = choice_w(NUM_CHOICES),
    localparam int QW = (NUM_QUESTIONS > 1) ? $clog2(NUM_QUESTIONS) : 1,
    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
    localparam int NB = NUM_PLAYERS * NUM_CHOICES
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NB-1:0]                  btn_n,
    input  logic [CW-1:0]                  ans_choice,
    output logic [QW-1:0]                  q_index,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score,
    output logic [NUM_PLAYERS-1:0]         lockout,
    output logic                           winner_valid,
    output logic [PW-1:0]                  winner_id,
    output logic                           beep
);

    state_t                                     state;
    logic [QW-1:0]                              q_q;
    logic [NUM_PLAYERS-1:0][SCORE_W-1:0]        score_q;
    logic [NUM_PLAYERS-1:0]                     lock_q, lock_next;
    logic [PW-1:0]                              win_id_q;
    logic                                       beep_q;

    logic [NB-1:0]                              btn_sync, btn_fall;
    logic [NUM_PLAYERS-1:0][NUM_CHOICES-1:0]    pad_fall;

    logic                                       any_valid, correct, wrong, timed_out;
    logic [PW-1:0]                              sel_p;
    logic [CW-1:0]                              sel_choice;
    logic [SCORE_W-1:0]                         cur_score, new_score;

    btn_sync_edge #(.W(NB)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_n),
        .sync (btn_sync),
        .fall (btn_fall)
    );

    assign pad_fall = btn_fall;

    // Scan high to low so the lowest-index valid pad is the last writer.
    always_comb begin
        any_valid  = 1'b0;
        sel_p      = '0;
        sel_choice = '0;
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            if (!lock_q[p] && $onehot(pad_fall[p])) begin
                any_valid = 1'b1;
                sel_p     = PW'(p);
                for (int c = 0; c < NUM_CHOICES; c++)
                    if (pad_fall[p][c]) sel_choice = CW'(c + 1);
            end
        end
    end

    assign correct   = any_valid && (ans_choice != '0) && (sel_choice == ans_choice);
    assign wrong     = any_valid && (ans_choice != '0) && (sel_choice != ans_choice);
    assign cur_score = score_q[sel_p];
    assign new_score = (cur_score == '1) ? cur_score : cur_score + SCORE_W'(1);
    assign lock_next = lock_q | (wrong ? (NUM_PLAYERS'(1) << sel_p) : '0);

`ifdef QUIZ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q;

    // Held at zero outside ASK, so every ASK visit starts from zero.
    always_ff @(posedge clk) begin
        if (rst || state != ST_ASK) timer_q <= '0;
        else                        timer_q <= timer_q + TW'(1);
    end

    assign timed_out = (timer_q == TW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timed_out      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_ASK;
            q_q      <= '0;
            score_q  <= '0;
            lock_q   <= '0;
            win_id_q <= '0;
            beep_q   <= 1'b0;
        end else begin
            beep_q <= 1'b0;
            case (state)
                ST_ASK: begin
                    if (correct) begin
                        score_q[sel_p] <= new_score;
                        beep_q         <= 1'b1;
                        if (new_score == SCORE_W'(WIN_SCORE)) begin
                            state    <= ST_DONE;
                            win_id_q <= sel_p;
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end else begin
                        lock_q <= lock_next;
                        if (&lock_next || timed_out) state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (&btn_sync) begin
                        q_q    <= (q_q == QW'(NUM_QUESTIONS - 1)) ? '0 : q_q + QW'(1);
                        lock_q <= '0;
                        state  <= ST_ASK;
                    end
                end
                ST_DONE:  beep_q <= 1'b1;
                default:  state  <= ST_ASK;
            endcase
        end
    end

    assign q_index      = q_q;
    assign score        = score_q;
    assign lockout      = lock_q;
    assign winner_valid = (state == ST_DONE);
    assign winner_id    = win_id_q;
    assign beep         = beep_q;

endmodule
